// File: rtl/riscv_crypto_share_masker_if.sv
// Handshake bundle for riscv_crypto_share_masker.
//   Input side : in_valid, in_ready, data_in (+ in_share_b when
//                RISCV_CRYPTO_MASK_REFRESH_EN is defined).
//   Output side: out_valid, out_ready, share_a, share_b.
//   slave modport = masker view, master modport = producer/consumer view.
interface riscv_crypto_share_masker_if;
  localparam int unsigned DATA_W = 32;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] data_in;
`ifdef RISCV_CRYPTO_MASK_REFRESH_EN
  logic [DATA_W-1:0] in_share_b;
`endif
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] share_a;
  logic [DATA_W-1:0] share_b;

`ifdef RISCV_CRYPTO_MASK_REFRESH_EN
  modport slave (
    input  in_valid, data_in, in_share_b, out_ready,
    output in_ready, out_valid, share_a, share_b
  );
  modport master (
    output in_valid, data_in, in_share_b, out_ready,
    input  in_ready, out_valid, share_a, share_b
  );
`else
  modport slave (
    input  in_valid, data_in, out_ready,
    output in_ready, out_valid, share_a, share_b
  );
  modport master (
    output in_valid, data_in, out_ready,
    input  in_ready, out_valid, share_a, share_b
  );
`endif
endinterface

// File: rtl/riscv_crypto_share_masker.sv
// Boolean masking front end: splits a word into share_a = data ^ m and
// share_b = m using a fresh mask m from a 32-bit Galois LFSR.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   seed_valid/seed : reload LFSR (zero seed maps to RESET_SEED), restarts warm-up
//   busy            : high while warming up
//   bus (slave)     : in_valid/in_ready/data_in, out_valid/out_ready/share_a/share_b
// Optional: define RISCV_CRYPTO_MASK_REFRESH_EN to add bus.in_share_b; the
// block then re-masks an already-shared word (share_b = in_share_b ^ m).
module riscv_crypto_share_masker #(
  parameter logic [31:0] RESET_SEED    = 32'hACE1_2468,
  parameter int unsigned WARMUP_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        seed_valid,
  input  logic [31:0] seed,
  output logic        busy,
  riscv_crypto_share_masker_if.slave bus
);
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 8;
  localparam logic [DATA_W-1:0] TAPS = 32'h8020_0003;

  typedef enum logic {ST_WARMUP, ST_RUN} state_t;

  state_t            state;
  logic [CNT_W-1:0]  warm_cnt;
  logic [DATA_W-1:0] lfsr;
  logic [DATA_W-1:0] lfsr_next;
  logic              out_valid_q;
  logic [DATA_W-1:0] share_a_q;
  logic [DATA_W-1:0] share_b_q;
  logic [DATA_W-1:0] partner_share;
  logic              accept;

  // Galois right-shift step; a nonzero state never maps to zero.
  always_comb begin
    lfsr_next = {1'b0, lfsr[DATA_W-1:1]} ^ (lfsr[0] ? TAPS : '0);
  end

`ifdef RISCV_CRYPTO_MASK_REFRESH_EN
  assign partner_share = bus.in_share_b;
`else
  assign partner_share = '0;
`endif

  // Reseed takes priority over an accept in the same cycle.
  assign bus.in_ready  = (state == ST_RUN) && !seed_valid &&
                         (!out_valid_q || bus.out_ready);
  assign accept        = bus.in_valid && bus.in_ready;
  assign busy          = (state == ST_WARMUP);
  assign bus.out_valid = out_valid_q;
  assign bus.share_a   = share_a_q;
  assign bus.share_b   = share_b_q;

  // LFSR, warm-up FSM and single-entry output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr        <= RESET_SEED;
      state       <= ST_WARMUP;
      warm_cnt    <= CNT_W'(WARMUP_CYCLES);
      out_valid_q <= 1'b0;
      share_a_q   <= '0;
      share_b_q   <= '0;
    end else begin
      if (seed_valid) begin
        lfsr     <= (seed == '0) ? RESET_SEED : seed;
        state    <= ST_WARMUP;
        warm_cnt <= CNT_W'(WARMUP_CYCLES);
      end else begin
        lfsr <= lfsr_next;
        case (state)
          ST_WARMUP: begin
            warm_cnt <= warm_cnt - CNT_W'(1);
            if (warm_cnt == CNT_W'(1)) state <= ST_RUN;
          end
          default: state <= ST_RUN;
        endcase
      end

      // Mask is the LFSR value current at acceptance; shares hold otherwise.
      if (accept) begin
        out_valid_q <= 1'b1;
        share_a_q   <= bus.data_in ^ lfsr;
        share_b_q   <= partner_share ^ lfsr;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_riscv_crypto_share_masker.sv
// Scoreboard bench for riscv_crypto_share_masker (WARMUP_CYCLES = 4).
module tb_riscv_crypto_share_masker;
  localparam logic [31:0] SEED0 = 32'hACE1_2468;
  localparam int unsigned WARM  = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        seed_valid;
  logic [31:0] seed;
  logic        busy;

  riscv_crypto_share_masker_if bus();

  riscv_crypto_share_masker #(
    .RESET_SEED   (SEED0),
    .WARMUP_CYCLES(WARM)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .seed_valid(seed_valid),
    .seed      (seed),
    .busy      (busy),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  logic [31:0] m_lfsr;
  logic [31:0] exp_a_q[$];
  logic [31:0] exp_b_q[$];
  logic [31:0] seen_b[$];
  logic [31:0] last_a, last_b;

  function automatic logic [31:0] step(input logic [31:0] v);
    logic [31:0] r;
    r = v >> 1;
    if (v[0]) r = r ^ 32'h8020_0003;
    return r;
  endfunction

  function automatic logic [31:0] step_n(input logic [31:0] v, input int n);
    logic [31:0] r;
    r = v;
    for (int i = 0; i < n; i++) r = step(r);
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Reference mask generator, same cadence as the block.
  always @(posedge clk) begin
    if (reset)           m_lfsr <= SEED0;
    else if (seed_valid) m_lfsr <= (seed == 32'h0) ? SEED0 : seed;
    else                 m_lfsr <= step(m_lfsr);
  end

  // Scoreboard: push expected shares for every accept seen before the edge.
  always @(negedge clk) begin
    logic [31:0] a, b, pb;
    if (reset) begin
      exp_a_q.delete();
      exp_b_q.delete();
    end else if (bus.in_valid && bus.in_ready) begin
`ifdef RISCV_CRYPTO_MASK_REFRESH_EN
      pb = bus.in_share_b;
`else
      pb = 32'h0;
`endif
      a = bus.data_in ^ m_lfsr;
      b = pb ^ m_lfsr;
      exp_a_q.push_back(a);
      exp_b_q.push_back(b);
      last_a = a;
      last_b = b;
    end
  end

  // Monitor: pop and compare on every output transfer.
  always @(negedge clk) begin
    if (!reset && bus.out_valid && bus.out_ready) begin
      if (exp_a_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_output: got share_a %h share_b %h, required none", bus.share_a, bus.share_b);
      end else begin
        check("share_a", bus.share_a, exp_a_q.pop_front());
        check("share_b", bus.share_b, exp_b_q.pop_front());
        seen_b.push_back(bus.share_b);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] words [8] = '{32'h0000_0000, 32'hFFFF_FFFF, 32'hA5A5_5A5A, 32'h1357_9BDF,
                             32'h8000_0001, 32'h0F0F_F0F0, 32'hCAFE_F00D, 32'h0000_0000};

  initial begin
    int dups, zeros;
    logic [31:0] g;
    reset = 1'b1; seed_valid = 1'b0; seed = 32'h0;
    bus.in_valid = 1'b0; bus.data_in = 32'h0; bus.out_ready = 1'b0;
`ifdef RISCV_CRYPTO_MASK_REFRESH_EN
    bus.in_share_b = 32'h0;
`endif
    tick(); tick();
    // Reset state
    check("rst_out_valid", 32'(bus.out_valid), 32'h0);
    check("rst_share_a", bus.share_a, 32'h0);
    check("rst_share_b", bus.share_b, 32'h0);
    check("rst_in_ready", 32'(bus.in_ready), 32'h0);
    check("rst_busy", 32'(busy), 32'h1);
    reset = 1'b0;
    bus.out_ready = 1'b1;
    #1;

    // 1. Warm-up lasts exactly WARM cycles
    for (int i = 0; i < int'(WARM); i++) begin
      check("warm_busy", 32'(busy), 32'h1);
      check("warm_in_ready", 32'(bus.in_ready), 32'h0);
      check("warm_out_valid", 32'(bus.out_valid), 32'h0);
      tick();
    end
    check("run_in_ready", 32'(bus.in_ready), 32'h1);
    check("run_busy", 32'(busy), 32'h0);
    tick();

    // 2. First word, mask = seed stepped 5 times
    bus.in_valid = 1'b1; bus.data_in = 32'h0123_4567;
    tick();
    bus.in_valid = 1'b0;
    check("t2_out_valid", 32'(bus.out_valid), 32'h1);
    check("t2_xor", bus.share_a ^ bus.share_b, 32'h0123_4567);
    check("t2_mask", bus.share_b, step_n(SEED0, 5));
    tick();
    check("t2_drained", 32'(bus.out_valid), 32'h0);

    // 3. Stream 8 words at full rate
    seen_b.delete();
    for (int i = 0; i < 8; i++) begin
      bus.in_valid = 1'b1; bus.data_in = words[i];
      tick();
      check("t3_out_valid", 32'(bus.out_valid), 32'h1);
    end
    bus.in_valid = 1'b0;
    tick(); tick();
    check("t3_count", 32'(seen_b.size()), 32'd8);
    dups = 0; zeros = 0;
    for (int i = 0; i < seen_b.size(); i++) begin
      if (seen_b[i] == 32'h0) zeros++;
      for (int j = i + 1; j < seen_b.size(); j++)
        if (seen_b[i] == seen_b[j]) dups++;
    end
    check("t3_mask_dups", 32'(dups), 32'h0);
    check("t3_mask_zero", 32'(zeros), 32'h0);

    // 4. Backpressure holds shares, then drain + accept in one cycle
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.data_in = 32'h1111_2222;
    tick();
    bus.data_in = 32'h3333_4444;
    #1;
    for (int i = 0; i < 10; i++) begin
      check("t4_hold_valid", 32'(bus.out_valid), 32'h1);
      check("t4_hold_ready", 32'(bus.in_ready), 32'h0);
      check("t4_hold_a", bus.share_a, last_a);
      check("t4_hold_b", bus.share_b, last_b);
      check("t4_hold_xor", bus.share_a ^ bus.share_b, 32'h1111_2222);
      tick();
    end
    bus.out_ready = 1'b1;
    #1;
    check("t4_ready_on_drain", 32'(bus.in_ready), 32'h1);
    tick();
    bus.in_valid = 1'b0;
    check("t4_next_valid", 32'(bus.out_valid), 32'h1);
    check("t4_next_xor", bus.share_a ^ bus.share_b, 32'h3333_4444);
    tick();

    // 5. Zero reseed beats in_valid; held output drains during warm-up
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.data_in = 32'h5555_6666;
    tick();
    seed_valid = 1'b1; seed = 32'h0; bus.data_in = 32'h7777_8888;
    #1;
    check("t5_no_accept", 32'(bus.in_ready), 32'h0);
    tick();
    seed_valid = 1'b0;
    for (int i = 0; i < int'(WARM); i++) begin
      check("t5_busy", 32'(busy), 32'h1);
      check("t5_in_ready", 32'(bus.in_ready), 32'h0);
      if (i == 0) begin
        check("t5_held_xor", bus.share_a ^ bus.share_b, 32'h5555_6666);
        bus.out_ready = 1'b1;
      end else begin
        check("t5_drained", 32'(bus.out_valid), 32'h0);
      end
      tick();
    end
    check("t5_run", 32'(busy), 32'h0);
    tick();
    bus.in_valid = 1'b0;
    check("t5_xor", bus.share_a ^ bus.share_b, 32'h7777_8888);
    check("t5_mask_reload", bus.share_b, step_n(SEED0, int'(WARM)));
    tick();

`ifdef RISCV_CRYPTO_MASK_REFRESH_EN
    // 6. Refresh of an already-shared word
    bus.in_valid = 1'b1; bus.data_in = 32'hDEAD_BEEF; bus.in_share_b = 32'h1234_5678;
    tick();
    bus.in_valid = 1'b0; bus.in_share_b = 32'h0;
    check("t6_xor", bus.share_a ^ bus.share_b, 32'hCC99_E897);
    n_vec++;
    if (bus.share_b == 32'h1234_5678) begin
      n_bad++;
      $display("FAIL t6_remasked: got share_b %h, required any other value", bus.share_b);
    end
    tick();
`endif

    // Reset mid-operation discards pending output; seed_valid in reset ignored
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.data_in = 32'h9999_AAAA;
    tick();
    bus.in_valid = 1'b0;
    reset = 1'b1; seed_valid = 1'b1; seed = 32'h1111_1111;
    tick();
    check("rst2_out_valid", 32'(bus.out_valid), 32'h0);
    check("rst2_share_a", bus.share_a, 32'h0);
    check("rst2_busy", 32'(busy), 32'h1);
    reset = 1'b0; seed_valid = 1'b0; bus.out_ready = 1'b1;
    #1;
    for (int i = 0; i < int'(WARM); i++) tick();
    bus.in_valid = 1'b1; bus.data_in = 32'hBBBB_CCCC;
    tick();
    bus.in_valid = 1'b0;
    check("rst2_xor", bus.share_a ^ bus.share_b, 32'hBBBB_CCCC);
    check("rst2_mask", bus.share_b, step_n(SEED0, int'(WARM)));
    tick(); tick();

    check("scoreboard_empty", 32'(exp_a_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
